sw_debounce_capture: RTL

//  Board-input receiver for the SW[15:0] slide switches: 2-flop synchronizer, whole-vector

---
 rtl/io_pkg.sv | 13 +
 rtl/sync_2ff.sv | 27 ++
 rtl/sw_debounce_capture.sv | 95 +++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the board I/O receive path.
package io_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      SETTLE = 1'b1
   } state_e;

   localparam int SW_WIDTH       = 16;
   localparam int SIM_DEBOUNCE   = 16;
   localparam int BOARD_DEBOUNCE = 1_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a vector of asynchronous inputs.
module sync_2ff #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] s1_q;
   logic [WIDTH-1:0] s2_q;

   // First flop may go metastable; second flop gives it a full cycle to resolve.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/sw_debounce_capture.sv
// Slide-switch receiver: synchronizes SW, debounces the whole vector, and keeps a
// sticky mask of changed bits that the processor reads and acknowledges.
module sw_debounce_capture
   import io_pkg::*;
#(
   parameter int WIDTH           = SW_WIDTH,
   parameter int DEBOUNCE_CYCLES = SIM_DEBOUNCE
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic [WIDTH-1:0] SW,
   output logic [WIDTH-1:0] SwStable,
   output logic [WIDTH-1:0] SwChanged,
   output logic             SwEvent,
   input  logic             RdAck
);

   localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sw_s2;
   state_e           state_q;
   logic [WIDTH-1:0] cand_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] stable_q;
   logic [WIDTH-1:0] changed_q;
   logic [WIDTH-1:0] changed_d;
   logic             event_q;
   logic             commit;

   sync_2ff #(
      .WIDTH (WIDTH)
   ) u_sync (
      .clk_i  (CLK),
      .rst_ni (Reset),
      .d_i    (SW),
      .q_o    (sw_s2)
   );

   // Candidate has been seen unchanged for the full settle window.
   assign commit = (state_q == SETTLE) && (sw_s2 == cand_q) && (cnt_q == CNT_LAST);

   // Ack clears old bits first, so a change committed on the ack edge still survives.
   always_comb begin
      changed_d = RdAck ? '0 : changed_q;
      if (commit) begin
         changed_d = changed_d | (stable_q ^ cand_q);
      end
   end

   // Debounce FSM with settle counter, committed value and sticky event register.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q   <= IDLE;
         cand_q    <= '0;
         cnt_q     <= '0;
         stable_q  <= '0;
         changed_q <= '0;
         event_q   <= 1'b0;
      end else begin
         changed_q <= changed_d;
         event_q   <= |changed_d;
         case (state_q)
            IDLE: begin
               if (sw_s2 != stable_q) begin
                  cand_q  <= sw_s2;
                  cnt_q   <= '0;
                  state_q <= SETTLE;
               end
            end
            SETTLE: begin
               if (sw_s2 != cand_q) begin
                  // Bounce restarts the window; bouncing back to the committed value is a glitch.
                  cand_q <= sw_s2;
                  cnt_q  <= '0;
                  if (sw_s2 == stable_q) begin
                     state_q <= IDLE;
                  end
               end else if (cnt_q != CNT_LAST) begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end else begin
                  stable_q <= cand_q;
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign SwStable  = stable_q;
   assign SwChanged = changed_q;
   assign SwEvent   = event_q;

endmodule
